// File: rtl/ysyx_24110015_imem_slave.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_imem_slave
//
// Instruction-memory slave for a fetch unit. Holds 2^AW 32-bit words mapped
// at byte address BASE. A single outstanding fetch is accepted in IDLE. The
// word is read at the accept edge and returned LATENCY cycles later. A side
// loader port fills the memory at any time, including during reset.
//
// Parameters
//   AW       log2 of the memory depth in words
//   LATENCY  cycles from the accept edge to resp_valid (must be >= 1)
//   BASE     byte address of word 0
//
// Ports
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset (memory contents untouched)
//   req_valid   fetch request present
//   req_ready   request can be accepted (IDLE and not in reset)
//   req_addr    byte address of the fetch
//   resp_valid  rdata/resp_err valid
//   resp_ready  initiator consumes the response
//   rdata       fetched instruction word (0 on error)
//   resp_err    fetch was misaligned or outside the mapped window
//   ld_en       loader write strobe
//   ld_addr     loader word index
//   ld_data     loader write data
// ---------------------------------------------------------------------------
module ysyx_24110015_imem_slave #(
  parameter int          AW      = 10,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   rdata,
  output logic          resp_err,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int DEPTH = 1 << AW;
  // The counter only ever holds values up to LATENCY-1.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic [31:0] mem [DEPTH];

  logic [31:0]   offset;
  logic [31:0]   idx_full;
  logic [AW-1:0] idx;
  logic          fetch_err;
  logic          accept;

  // Modulo-2^32 subtraction: addresses below BASE wrap to huge indices, but
  // they are flagged explicitly as well so the error does not depend on AW.
  assign offset    = req_addr - BASE;
  assign idx_full  = offset >> 2;
  assign idx       = idx_full[AW-1:0];
  assign fetch_err = (req_addr[1:0] != 2'b00)
                  || (req_addr < BASE)
                  || ((idx_full >> AW) != 32'd0);

  assign req_ready  = (state == IDLE) && !rst;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // NOTE: the memory array has no reset on purpose; resetting it would turn
  // it into a huge bank of flops and would wipe a program loaded during reset.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments, so the read of
  // mem[idx] below sees the pre-edge contents even when the loader writes the
  // same word at the same edge (read-before-write).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rdata    <= '0;
      resp_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rdata    <= fetch_err ? 32'd0 : mem[idx];
            resp_err <= fetch_err;
            cnt      <= CNT_LOAD;
            state    <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          // rdata/resp_err stay frozen until the handshake.
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24110015_imem_slave.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110015_imem_slave
//
// Three instances (LATENCY = 1, 3, 4) share clk, rst and the loader port, so
// every instance holds the same memory image. Each has its own request and
// response signals. Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ysyx_24110015_imem_slave;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] rdata      [3];
  logic        resp_err   [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_24110015_imem_slave #(
      .AW      (AW),
      .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .BASE    (32'h8000_0000)
    ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_addr   (req_addr[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .rdata      (rdata[g]),
      .resp_err   (resp_err[g]),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  // Full fetch on instance k with known latency; any loader strobe already
  // set up by the caller lands on the accept edge and is dropped afterwards.
  task automatic fetch(input int k, input int lat, input logic [31:0] addr,
                       input logic [31:0] exp_d, input logic exp_e,
                       input string tag);
    req_valid[k]  = 1'b1;
    req_addr[k]   = addr;
    resp_ready[k] = 1'b0;
    step();
    req_valid[k] = 1'b0;
    ld_en        = 1'b0;
    for (int i = 1; i < lat; i++) begin
      check({tag, " early resp_valid"}, 32'(resp_valid[k]), 32'd0);
      step();
    end
    check({tag, " resp_valid"}, 32'(resp_valid[k]), 32'd1);
    check({tag, " rdata"}, rdata[k], exp_d);
    check({tag, " resp_err"}, 32'(resp_err[k]), 32'(exp_e));
    resp_ready[k] = 1'b1;
    step();
    resp_ready[k] = 1'b0;
    check({tag, " resp_valid after hs"}, 32'(resp_valid[k]), 32'd0);
    check({tag, " req_ready after hs"}, 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_addr[k]   = '0;
      resp_ready[k] = 1'b0;
    end

    // Loader writes while reset is held.
    load(10'd0,    32'h0000_0413);
    load(10'd1,    32'h00A0_0093);
    load(10'd5,    32'h1111_1111);
    load(10'd1023, 32'h1234_5678);

    for (int k = 0; k < 3; k++) begin
      check("reset req_ready",  32'(req_ready[k]),  32'd0);
      check("reset resp_valid", 32'(resp_valid[k]), 32'd0);
      check("reset rdata",      rdata[k],           32'd0);
      check("reset resp_err",   32'(resp_err[k]),   32'd0);
    end

    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("req_ready after reset", 32'(req_ready[k]), 32'd1);
    end

    // LATENCY=1 basic fetch of word 0.
    fetch(0, 1, 32'h8000_0000, 32'h0000_0413, 1'b0, "lat1 word0");

    // LATENCY=3 with back-pressure, ignored request and loader write in RESP.
    req_valid[1]  = 1'b1;
    req_addr[1]   = 32'h8000_0004;
    resp_ready[1] = 1'b0;
    check("lat3 req_ready at accept", 32'(req_ready[1]), 32'd1);
    step();
    req_valid[1] = 1'b0;
    check("lat3 cycle1 resp_valid", 32'(resp_valid[1]), 32'd0);
    check("lat3 cycle1 req_ready",  32'(req_ready[1]),  32'd0);
    step();
    check("lat3 cycle2 resp_valid", 32'(resp_valid[1]), 32'd0);
    step();
    check("lat3 cycle3 resp_valid", 32'(resp_valid[1]), 32'd1);
    check("lat3 cycle3 rdata",      rdata[1],           32'h00A0_0093);
    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h8000_0000;
    ld_en   = 1'b1;
    ld_addr = 10'd1;
    ld_data = 32'hCAFE_F00D;
    step();
    req_valid[1] = 1'b0;
    ld_en        = 1'b0;
    check("lat3 cycle4 resp_valid held", 32'(resp_valid[1]), 32'd1);
    check("lat3 cycle4 rdata held",      rdata[1],           32'h00A0_0093);
    check("lat3 cycle4 resp_err held",   32'(resp_err[1]),   32'd0);
    check("lat3 cycle4 req_ready",       32'(req_ready[1]),  32'd0);
    resp_ready[1] = 1'b1;
    step();
    resp_ready[1] = 1'b0;
    check("lat3 after hs resp_valid", 32'(resp_valid[1]), 32'd0);
    check("lat3 after hs req_ready",  32'(req_ready[1]),  32'd1);
    step();
    check("lat3 ignored req no resp", 32'(resp_valid[1]), 32'd0);
    fetch(1, 3, 32'h8000_0004, 32'hCAFE_F00D, 1'b0, "lat3 reload word1");

    // Error and boundary addresses on the LATENCY=1 instance.
    fetch(0, 1, 32'h8000_0002, 32'd0, 1'b1, "err misaligned");
    fetch(0, 1, 32'h7FFF_FFFC, 32'd0, 1'b1, "err below base");
    fetch(0, 1, 32'h8000_1000, 32'd0, 1'b1, "err past end");
    fetch(0, 1, 32'h8000_0FFC, 32'h1234_5678, 1'b0, "last word");

    // Same-edge loader write and accept: old data first, new data next.
    ld_en   = 1'b1;
    ld_addr = 10'd5;
    ld_data = 32'hDEAD_BEEF;
    fetch(0, 1, 32'h8000_0014, 32'h1111_1111, 1'b0, "rbw old");
    fetch(0, 1, 32'h8000_0014, 32'hDEAD_BEEF, 1'b0, "rbw new");

    // LATENCY=4 normal fetch.
    fetch(2, 4, 32'h8000_0000, 32'h0000_0413, 1'b0, "lat4 word0");

    // LATENCY=4: reset two cycles after accept discards the transaction.
    req_valid[2] = 1'b1;
    req_addr[2]  = 32'h8000_0014;
    step();
    req_valid[2] = 1'b0;
    check("lat4 abort cycle1 resp_valid", 32'(resp_valid[2]), 32'd0);
    step();
    rst = 1'b1;
    step();
    check("lat4 abort in reset resp_valid", 32'(resp_valid[2]), 32'd0);
    check("lat4 abort in reset req_ready",  32'(req_ready[2]),  32'd0);
    rst = 1'b0;
    #1;
    check("lat4 abort req_ready after rst", 32'(req_ready[2]), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("lat4 abort no resp", 32'(resp_valid[2]), 32'd0);
    end
    fetch(2, 4, 32'h8000_0014, 32'hDEAD_BEEF, 1'b0, "lat4 mem kept w5");
    fetch(2, 4, 32'h8000_0004, 32'hCAFE_F00D, 1'b0, "lat4 mem kept w1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
